// File: rtl/gci_hub_node_arbiter_if.sv
// Node request / grant bundle between the GCI nodes, the hub bus mux and the arbiter.
// The arbiter takes the slave side; the request source (nodes and bus) takes the master side.
interface gci_hub_node_arbiter_if;
    logic       iNODE1_REQ;
    logic [7:0] iNODE1_PRIORITY;
    logic       iNODE2_REQ;
    logic [7:0] iNODE2_PRIORITY;
    logic       iNODE3_REQ;
    logic [7:0] iNODE3_PRIORITY;
    logic       iNODE4_REQ;
    logic [7:0] iNODE4_PRIORITY;
    logic       iBUS_DONE;
    logic       oNODE1_GNT;
    logic       oNODE2_GNT;
    logic       oNODE3_GNT;
    logic       oNODE4_GNT;
    logic       oGRANT_VALID;
    logic [1:0] oGRANT_NODE;
    logic       oTIMEOUT;

    modport master (
        output iNODE1_REQ, iNODE1_PRIORITY, iNODE2_REQ, iNODE2_PRIORITY,
               iNODE3_REQ, iNODE3_PRIORITY, iNODE4_REQ, iNODE4_PRIORITY,
               iBUS_DONE,
        input  oNODE1_GNT, oNODE2_GNT, oNODE3_GNT, oNODE4_GNT,
               oGRANT_VALID, oGRANT_NODE, oTIMEOUT
    );

    modport slave (
        input  iNODE1_REQ, iNODE1_PRIORITY, iNODE2_REQ, iNODE2_PRIORITY,
               iNODE3_REQ, iNODE3_PRIORITY, iNODE4_REQ, iNODE4_PRIORITY,
               iBUS_DONE,
        output oNODE1_GNT, oNODE2_GNT, oNODE3_GNT, oNODE4_GNT,
               oGRANT_VALID, oGRANT_NODE, oTIMEOUT
    );
endinterface

// File: rtl/gci_hub_node_arbiter.sv
// Four-node GCI hub bus arbiter: highest priority wins, ties broken round-robin,
// grant held until bus done, requester withdrawal or hold timeout.
module gci_hub_node_arbiter #(
    parameter int unsigned P_TIMEOUT   = 256,
    parameter int unsigned P_TIMEOUT_W = 16
) (
    input logic                   iCLOCK,
    input logic                   iRESET_SYNC,
    gci_hub_node_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    localparam logic [P_TIMEOUT_W-1:0] CNT_LIMIT = P_TIMEOUT_W'(P_TIMEOUT - 1);
    localparam logic [P_TIMEOUT_W-1:0] CNT_ONE   = P_TIMEOUT_W'(1);

    state_t                 state;
    logic [1:0]             rr_ptr;
    logic [P_TIMEOUT_W-1:0] hold_cnt;
    logic [3:0]             gnt;
    logic                   grant_valid;
    logic [1:0]             grant_node;
    logic                   timeout;

    logic [3:0] req;
    logic [7:0] pri [4];
    logic       win_found;
    logic [1:0] win_idx;
    logic [7:0] win_pri;
    logic       hit_limit;
    logic       owner_req;
    logic       grant_exit;

    assign req    = {bus.iNODE4_REQ, bus.iNODE3_REQ, bus.iNODE2_REQ, bus.iNODE1_REQ};
    assign pri[0] = bus.iNODE1_PRIORITY;
    assign pri[1] = bus.iNODE2_PRIORITY;
    assign pri[2] = bus.iNODE3_PRIORITY;
    assign pri[3] = bus.iNODE4_PRIORITY;

    // Scan from rr_ptr; strict '>' keeps the first tied node in scan order.
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        win_pri   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = rr_ptr + k[1:0];
            if (req[idx] && (pri[idx] != 8'd0) && (!win_found || (pri[idx] > win_pri))) begin
                win_found = 1'b1;
                win_idx   = idx;
                win_pri   = pri[idx];
            end
        end
    end

    assign hit_limit  = (hold_cnt == CNT_LIMIT);
    assign owner_req  = req[grant_node];
    assign grant_exit = bus.iBUS_DONE || !owner_req || hit_limit;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            gnt         <= '0;
            grant_valid <= 1'b0;
            grant_node  <= '0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt         <= 4'b0001 << win_idx;
                        grant_valid <= 1'b1;
                        grant_node  <= win_idx;
                        hold_cnt    <= '0;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Reaching the limit always exits, so the counter saturates implicitly.
                    if (grant_exit) begin
                        gnt         <= '0;
                        grant_valid <= 1'b0;
                        rr_ptr      <= grant_node + 2'd1;
                        timeout     <= hit_limit && !bus.iBUS_DONE && owner_req;
                        state       <= S_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign bus.oNODE1_GNT   = gnt[0];
    assign bus.oNODE2_GNT   = gnt[1];
    assign bus.oNODE3_GNT   = gnt[2];
    assign bus.oNODE4_GNT   = gnt[3];
    assign bus.oGRANT_VALID = grant_valid;
    assign bus.oGRANT_NODE  = grant_node;
    assign bus.oTIMEOUT     = timeout;

endmodule

// File: tb/tb_gci_hub_node_arbiter.sv
// Bench for gci_hub_node_arbiter: directed scenarios then random traffic, every
// cycle compared against a behavioural model of the arbitration rules.
module tb_gci_hub_node_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] pri [4];
    logic       done = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, how long, and the enforced dead time.
    int owner     = -1;
    int held      = 0;
    int cool      = 0;
    int rr        = 0;
    int last_node = 0;
    bit to_exp    = 1'b0;

    gci_hub_node_arbiter_if bus ();

    assign bus.iNODE1_REQ      = req[0];
    assign bus.iNODE2_REQ      = req[1];
    assign bus.iNODE3_REQ      = req[2];
    assign bus.iNODE4_REQ      = req[3];
    assign bus.iNODE1_PRIORITY = pri[0];
    assign bus.iNODE2_PRIORITY = pri[1];
    assign bus.iNODE3_PRIORITY = pri[2];
    assign bus.iNODE4_PRIORITY = pri[3];
    assign bus.iBUS_DONE       = done;

    gci_hub_node_arbiter #(.P_TIMEOUT(TO), .P_TIMEOUT_W(16)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] g;
    assign g = {bus.oNODE4_GNT, bus.oNODE3_GNT, bus.oNODE2_GNT, bus.oNODE1_GNT};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  best;
        bit  found;
        bit  by_done;
        bit  by_drop;
        bit  by_limit;
        to_exp = 1'b0;
        if (rst) begin
            owner = -1; held = 0; cool = 0; rr = 0; last_node = 0;
        end else if (owner >= 0) begin
            by_done  = done;
            by_drop  = !req[owner];
            by_limit = (held == TO - 1);
            if (by_done || by_drop || by_limit) begin
                to_exp = by_limit && !by_done && !by_drop;
                rr     = (owner + 1) % 4;
                owner  = -1;
                cool   = 1;
            end else begin
                held++;
            end
        end else if (cool > 0) begin
            cool--;
        end else begin
            best = 0;
            for (int i = 0; i < 4; i++)
                if (req[i] && pri[i] != 0 && int'(pri[i]) > best) best = int'(pri[i]);
            found = 1'b0;
            if (best > 0) begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (rr + k) % 4;
                    if (!found && req[j] && int'(pri[j]) == best) begin
                        found = 1'b1; owner = j; held = 0; last_node = j;
                    end
                end
            end
        end
    endtask

    task automatic step(input string tag);
        logic [7:0] exp_v;
        logic [3:0] exp_g;
        @(posedge clk);
        model_edge();
        #1;
        exp_g = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        exp_v = {exp_g, (owner >= 0), 2'(last_node), to_exp};
        chk(tag, 32'({g, bus.oGRANT_VALID, bus.oGRANT_NODE, bus.oTIMEOUT}), 32'(exp_v));
        chk("onehot", 32'($onehot0(g)), 32'd1);
    endtask

    task automatic settle();
        req  = '0;
        done = 1'b0;
        repeat (3) step("settle");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        int gcnt;
        for (int i = 0; i < 4; i++) pri[i] = 8'h00;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(bus.oGRANT_VALID), 32'd0);
        chk("rst_node", 32'(bus.oGRANT_NODE), 32'd0);
        step("idle");

        // Highest priority wins, one cycle after request sampled
        pri[0] = 8'h10; pri[1] = 8'h20; pri[2] = 8'h30; pri[3] = 8'h05;
        req = 4'b1111;
        step("t1_grant");
        chk("t1_node", 32'(bus.oGRANT_NODE), 32'd2);
        chk("t1_gnt", 32'(g), 32'b0100);
        settle();

        // Equal priorities rotate 1,2,3,4,1 with two grant-free cycles
        do_reset();
        for (int i = 0; i < 4; i++) pri[i] = 8'h08;
        req = 4'b1111;
        step("rr_first");
        chk("rr_node0", 32'(bus.oGRANT_NODE), 32'd0);
        for (int n = 1; n <= 4; n++) begin
            step("rr_hold");
            step("rr_hold");
            done = 1'b1;
            step("rr_done");
            done = 1'b0;
            chk("rr_gap1", 32'(bus.oGRANT_VALID), 32'd0);
            step("rr_gap");
            chk("rr_gap2", 32'(bus.oGRANT_VALID), 32'd0);
            step("rr_next");
            chk("rr_node", 32'(bus.oGRANT_NODE), 32'(n % 4));
            chk("rr_valid", 32'(bus.oGRANT_VALID), 32'd1);
        end
        settle();

        // Hold timeout on node 2
        pri[1] = 8'h05; req = 4'b0010;
        step("to_grant");
        chk("to_gnt2", 32'(g), 32'b0010);
        gcnt = 1;
        for (int i = 0; i < 10; i++) begin
            if (bus.oGRANT_VALID !== 1'b1) break;
            step("to_hold");
            if (bus.oGRANT_VALID === 1'b1) gcnt++;
        end
        chk("to_cycles", 32'(gcnt), 32'd4);
        chk("to_pulse", 32'(bus.oTIMEOUT), 32'd1);
        step("to_gap");
        chk("to_pulse_end", 32'(bus.oTIMEOUT), 32'd0);
        step("to_regrant");
        chk("to_regrant_node", 32'(bus.oGRANT_NODE), 32'd1);
        chk("to_regrant_valid", 32'(bus.oGRANT_VALID), 32'd1);
        settle();

        // Priority zero disables a requester
        pri[0] = 8'h00; pri[3] = 8'h01; req = 4'b1001;
        step("dis_grant");
        chk("dis_node4", 32'(g), 32'b1000);
        settle();
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step("dis_none");
            chk("dis_no_grant", 32'(bus.oGRANT_VALID), 32'd0);
        end
        settle();

        // Done coincides with limit: normal release, no pulse
        pri[1] = 8'h05; req = 4'b0010;
        step("dt_grant");
        repeat (3) step("dt_hold");
        done = 1'b1;
        step("dt_exit");
        done = 1'b0;
        chk("dt_valid", 32'(bus.oGRANT_VALID), 32'd0);
        chk("dt_no_pulse", 32'(bus.oTIMEOUT), 32'd0);
        settle();

        // Reset mid-grant clears everything and the round-robin pointer
        for (int i = 0; i < 4; i++) pri[i] = 8'h10;
        pri[2] = 8'h40; req = 4'b1111;
        step("mr_grant");
        chk("mr_node3", 32'(g), 32'b0100);
        rst = 1'b1;
        step("mr_reset");
        chk("mr_all_zero", 32'({g, bus.oGRANT_VALID, bus.oGRANT_NODE, bus.oTIMEOUT}), 32'd0);
        rst = 1'b0;
        pri[2] = 8'h10;
        step("mr_tie");
        chk("mr_tie_node1", 32'(g), 32'b0001);
        settle();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 4))
                        0:       pri[i] = 8'h00;
                        1:       pri[i] = 8'h01;
                        2, 3:    pri[i] = 8'h08;
                        default: pri[i] = 8'(200 + $urandom_range(0, 1));
                    endcase
                end
            end
            done = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
